// File: rtl/spi_ram_ctrl.sv
// SPI RAM controller: decodes 10-bit SPI slave words into address/data
// commands against a single-port byte memory.
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   din       [9:8] command, [7:0] payload (valid when rx_valid)
//   rx_valid  qualifies din
//   dout      read data for the SPI slave tx path (held between reads)
//   tx_valid  one-cycle pulse qualifying dout
//   err       one-cycle pulse for a rejected command
module spi_ram_ctrl #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  logic [DATA_W-1:0]    mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_ok_q, wr_ok_d;
  logic                 rd_ok_q, rd_ok_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;
  logic                 mem_we;
  cmd_e                 cmd;
  logic [DATA_W-1:0]    payload;
  logic                 addr_in_range;

  // Address increment with wrap at the top of the populated range.
  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    if (32'(a) == MEM_DEPTH - 32'd1) return '0;
    return a + ADDR_SIZE'(1);
  endfunction

  // Command decode and next-state computation.
  always_comb begin
    cmd           = cmd_e'(din[9:8]);
    payload       = din[7:0];
    addr_in_range = (32'(payload) < MEM_DEPTH);
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_ok_d       = wr_ok_q;
    rd_ok_d       = rd_ok_q;
    dout_d        = dout_q;
    tx_valid_d    = 1'b0;
    err_d         = 1'b0;
    mem_we        = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          if (addr_in_range) begin
            wr_addr_d = ADDR_SIZE'(payload);
            wr_ok_d   = 1'b1;
          end else begin
            wr_ok_d = 1'b0;
            err_d   = 1'b1;
          end
        end
        CMD_WR_DATA: begin
          if (wr_ok_q) begin
            mem_we    = 1'b1;
            wr_addr_d = addr_inc(wr_addr_q);
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          if (addr_in_range) begin
            rd_addr_d = ADDR_SIZE'(payload);
            rd_ok_d   = 1'b1;
          end else begin
            rd_ok_d = 1'b0;
            err_d   = 1'b1;
          end
        end
        CMD_RD_DATA: begin
          if (rd_ok_q) begin
            dout_d     = mem[rd_addr_q];
            tx_valid_d = 1'b1;
            rd_addr_d  = addr_inc(rd_addr_q);
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_ok_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_ok_q    <= wr_ok_d;
      rd_ok_q    <= rd_ok_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[wr_addr_q] <= payload;
  end

  // Masking with rst kills a read response whose cycle coincides with reset.
  assign dout     = rst ? '0 : dout_q;
  assign tx_valid = tx_valid_q & ~rst;
  assign err      = err_q & ~rst;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
module tb_spi_ram_ctrl;

  localparam logic [1:0] WA = 2'b00, WD = 2'b01, RA = 2'b10, RD = 2'b11;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, rx_valid = 1'b0;
  logic [9:0] din = '0;
  logic [7:0] dout;
  logic       tx_valid, err;

  logic       rst2 = 1'b1, rx_valid2 = 1'b0;
  logic [9:0] din2 = '0;
  logic [7:0] dout2;
  logic       tx_valid2, err2;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid), .err(err));

  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut200 (
    .clk(clk), .rst(rst2), .din(din2), .rx_valid(rx_valid2),
    .dout(dout2), .tx_valid(tx_valid2), .err(err2));

  int n_pass = 0;
  int n_total = 0;

  // Reference model of the 256-deep instance
  logic [7:0] m_mem [256];
  int         m_wr = 0, m_rd = 0;
  bit         m_wok = 0, m_rok = 0;
  logic [7:0] exp_dout = '0;
  logic       exp_tx = 1'b0, exp_err = 1'b0;

  function automatic void model_step(input logic r, input logic v,
                                     input logic [1:0] c, input logic [7:0] p);
    exp_tx  = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      m_wr = 0; m_rd = 0; m_wok = 0; m_rok = 0; exp_dout = '0;
      return;
    end
    if (!v) return;
    case (c)
      WA: if (int'(p) < 256) begin m_wr = int'(p); m_wok = 1; end
          else begin m_wok = 0; exp_err = 1'b1; end
      WD: if (m_wok) begin m_mem[m_wr] = p; m_wr = (m_wr + 1) % 256; end
          else exp_err = 1'b1;
      RA: if (int'(p) < 256) begin m_rd = int'(p); m_rok = 1; end
          else begin m_rok = 0; exp_err = 1'b1; end
      default: if (m_rok) begin exp_dout = m_mem[m_rd]; exp_tx = 1'b1; m_rd = (m_rd + 1) % 256; end
               else exp_err = 1'b1;
    endcase
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [1:0] c, input logic [7:0] p);
    rst = r; rx_valid = v; din = {c, p};
    model_step(r, v, c, p);
    @(posedge clk); #1;
  endtask

  task automatic cycle2(input logic r, input logic v, input logic [1:0] c, input logic [7:0] p);
    rst2 = r; rx_valid2 = v; din2 = {c, p};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, WA, 8'h00);
    cycle(1, 1, RD, 8'h00);
    n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx: got %b expected 0", tx_valid); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
    n_total++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else n_pass++;
    cycle(0, 0, WA, 8'h00);
    n_total++; if (dout !== 8'h00 || tx_valid !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_idle: got dout=%h tx=%b err=%b expected 00/0/0", dout, tx_valid, err);
    else n_pass++;
  endtask

  task automatic test_fill();
    cycle(0, 1, WA, 8'h00);
    for (int i = 0; i < 256; i++) begin
      cycle(0, 1, WD, 8'($urandom_range(0, 255)));
      n_total++; if (err !== 1'b0) $display("FAIL fill_err[%0d]: got %b expected 0", i, err); else n_pass++;
    end
  endtask

  task automatic test_write_read();
    logic [1:0] cs [4] = '{WA, WD, RA, RD};
    logic [7:0] ps [4] = '{8'h10, 8'hA5, 8'h10, 8'h00};
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, cs[i], ps[i]);
      n_total++; if (err !== 1'b0) $display("FAIL wr_rd_err[%0d]: got %b expected 0", i, err); else n_pass++;
    end
    n_total++; if (tx_valid !== 1'b1 || dout !== 8'hA5)
      $display("FAIL wr_rd_data: got tx=%b dout=%h expected 1/a5", tx_valid, dout);
    else n_pass++;
    cycle(0, 0, WA, 8'h00);
    n_total++; if (tx_valid !== 1'b0 || dout !== 8'hA5)
      $display("FAIL wr_rd_hold: got tx=%b dout=%h expected 0/a5", tx_valid, dout);
    else n_pass++;
    // Read the location written on the previous edge
    cycle(0, 1, WA, 8'h30);
    cycle(0, 1, RA, 8'h30);
    cycle(0, 1, WD, 8'h99);
    cycle(0, 1, RD, 8'h00);
    n_total++; if (tx_valid !== 1'b1 || dout !== 8'h99)
      $display("FAIL raw_fwd: got tx=%b dout=%h expected 1/99", tx_valid, dout);
    else n_pass++;
  endtask

  task automatic test_burst_wrap();
    cycle(0, 1, WA, 8'hFF);
    cycle(0, 1, WD, 8'h11);
    cycle(0, 1, WD, 8'h22);
    n_total++; if (err !== 1'b0) $display("FAIL wrap_wr_err: got %b expected 0", err); else n_pass++;
    cycle(0, 1, RA, 8'hFF);
    cycle(0, 1, RD, 8'h00);
    n_total++; if (tx_valid !== 1'b1 || dout !== 8'h11)
      $display("FAIL wrap_rd0: got tx=%b dout=%h expected 1/11", tx_valid, dout);
    else n_pass++;
    cycle(0, 1, RD, 8'h00);
    n_total++; if (tx_valid !== 1'b1 || dout !== 8'h22 || err !== 1'b0)
      $display("FAIL wrap_rd1: got tx=%b dout=%h err=%b expected 1/22/0", tx_valid, dout, err);
    else n_pass++;
    cycle(0, 1, RA, 8'h00);
    cycle(0, 1, RD, 8'h00);
    n_total++; if (dout !== 8'h22) $display("FAIL wrap_addr0: got %h expected 22", dout); else n_pass++;
  endtask

  task automatic test_unarmed();
    cycle(1, 0, WA, 8'h00);
    cycle(0, 1, RD, 8'h00);
    n_total++; if (err !== 1'b1 || tx_valid !== 1'b0)
      $display("FAIL unarmed_rd: got err=%b tx=%b expected 1/0", err, tx_valid);
    else n_pass++;
    cycle(0, 0, WA, 8'h00);
    n_total++; if (err !== 1'b0) $display("FAIL unarmed_pulse: got %b expected 0", err); else n_pass++;
    cycle(0, 1, WD, 8'hEE);
    n_total++; if (err !== 1'b1) $display("FAIL unarmed_wr: got %b expected 1", err); else n_pass++;
    cycle(0, 1, RA, 8'h00);
    cycle(0, 1, RD, 8'h00);
    n_total++; if (tx_valid !== 1'b1 || dout !== exp_dout)
      $display("FAIL unarmed_mem: got tx=%b dout=%h expected 1/%h", tx_valid, dout, exp_dout);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] cs [4] = '{WA, WD, RA, RD};
    logic [7:0] ps [4] = '{8'h05, 8'h3C, 8'h05, 8'h00};
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, cs[i], ps[i]);
      n_total++; if (err !== 1'b0) $display("FAIL b2b_err[%0d]: got %b expected 0", i, err); else n_pass++;
    end
    n_total++; if (tx_valid !== 1'b1 || dout !== 8'h3C)
      $display("FAIL b2b_data: got tx=%b dout=%h expected 1/3c", tx_valid, dout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, WA, 8'h40);
    cycle(0, 1, WD, 8'h9E);
    cycle(0, 1, RA, 8'h40);
    rst = 1'b0; rx_valid = 1'b1; din = {RD, 8'h00};
    model_step(0, 1, RD, 8'h00);
    @(posedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    #1;
    n_total++; if (tx_valid !== 1'b0 || dout !== 8'h00)
      $display("FAIL rstmid_tx: got tx=%b dout=%h expected 0/00", tx_valid, dout);
    else n_pass++;
    model_step(1, 0, WA, 8'h00);
    @(posedge clk); #1;
    n_total++; if (tx_valid !== 1'b0 || dout !== 8'h00 || err !== 1'b0)
      $display("FAIL rstmid_after: got tx=%b dout=%h err=%b expected 0/00/0", tx_valid, dout, err);
    else n_pass++;
    cycle(0, 1, RA, 8'h40);
    cycle(0, 1, RD, 8'h00);
    n_total++; if (tx_valid !== 1'b1 || dout !== 8'h9E)
      $display("FAIL rstmid_keep: got tx=%b dout=%h expected 1/9e", tx_valid, dout);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic r, v;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) != 0);
      cycle(r, v, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      n_total++; if (tx_valid !== exp_tx) $display("FAIL rand_tx[%0d]: got %b expected %b", i, tx_valid, exp_tx); else n_pass++;
      n_total++; if (err !== exp_err) $display("FAIL rand_err[%0d]: got %b expected %b", i, err, exp_err); else n_pass++;
      n_total++; if (dout !== exp_dout) $display("FAIL rand_dout[%0d]: got %h expected %h", i, dout, exp_dout); else n_pass++;
      n_total++; if ((tx_valid & err) !== 1'b0) $display("FAIL rand_excl[%0d]: got tx=%b err=%b expected not both", i, tx_valid, err); else n_pass++;
    end
  endtask

  task automatic test_range();
    cycle2(1, 0, WA, 8'h00);
    cycle2(0, 1, WA, 8'h10);
    cycle2(0, 1, WD, 8'h77);
    n_total++; if (err2 !== 1'b0) $display("FAIL range_ok: got %b expected 0", err2); else n_pass++;
    cycle2(0, 1, WA, 8'hC8);
    n_total++; if (err2 !== 1'b1) $display("FAIL range_addr: got %b expected 1", err2); else n_pass++;
    cycle2(0, 1, WD, 8'h55);
    n_total++; if (err2 !== 1'b1) $display("FAIL range_wd: got %b expected 1", err2); else n_pass++;
    cycle2(0, 1, WA, 8'hC7);
    cycle2(0, 1, WD, 8'h5A);
    cycle2(0, 1, WD, 8'h6B);
    n_total++; if (err2 !== 1'b0) $display("FAIL range_top: got %b expected 0", err2); else n_pass++;
    cycle2(0, 1, RA, 8'hC7);
    cycle2(0, 1, RD, 8'h00);
    n_total++; if (tx_valid2 !== 1'b1 || dout2 !== 8'h5A)
      $display("FAIL range_rd_top: got tx=%b dout=%h expected 1/5a", tx_valid2, dout2);
    else n_pass++;
    cycle2(0, 1, RD, 8'h00);
    n_total++; if (tx_valid2 !== 1'b1 || dout2 !== 8'h6B || err2 !== 1'b0)
      $display("FAIL range_rd_wrap: got tx=%b dout=%h err=%b expected 1/6b/0", tx_valid2, dout2, err2);
    else n_pass++;
    cycle2(0, 1, RA, 8'h10);
    cycle2(0, 1, RD, 8'h00);
    n_total++; if (dout2 !== 8'h77) $display("FAIL range_nowrite: got %h expected 77", dout2); else n_pass++;
    cycle2(0, 1, RA, 8'hC8);
    n_total++; if (err2 !== 1'b1) $display("FAIL range_ra: got %b expected 1", err2); else n_pass++;
    cycle2(0, 1, RD, 8'h00);
    n_total++; if (err2 !== 1'b1 || tx_valid2 !== 1'b0)
      $display("FAIL range_rd_disarm: got err=%b tx=%b expected 1/0", err2, tx_valid2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_burst_wrap();
    test_unarmed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_range();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
